// File: rtl/uart_reg_loader.sv
// UART receiver that turns each accepted byte into a 3-bit address / 5-bit data register write.
// Optional even-parity bit after data bit 7 is enabled by defining UART_PARITY_EN.
module uart_reg_loader #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       write_strobe,
   output logic [2:0] address,
   output logic [4:0] data,
   output logic       frame_error,
   output logic       busy
);

   localparam logic [11:0] HALF_C = 12'(CLKS_PER_BIT / 2);
   localparam logic [11:0] FULL_C = 12'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

   state_t      state_q, state_d;
   logic        rx_meta_q, rx_s_q;
   logic [11:0] timer_q, timer_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic [2:0]  addr_q, addr_d;
   logic [4:0]  data_q, data_d;
   logic        strobe_q, strobe_d;
   logic        ferr_q, ferr_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= IDLE;
         timer_q   <= '0;
         shift_q   <= '0;
         bitcnt_q  <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         strobe_q  <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         timer_q   <= timer_d;
         shift_q   <= shift_d;
         bitcnt_q  <= bitcnt_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strobe_q  <= strobe_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      strobe_d = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d  = '0;
            bitcnt_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            // Re-check the line half a bit later so short glitches are dropped.
            if (timer_q == HALF_C) begin
               timer_d = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end else begin
               timer_d = timer_q + 12'd1;
            end
         end
         DATA: begin
            if (timer_q == FULL_C) begin
               timer_d  = '0;
               shift_d  = {rx_s_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end else begin
               timer_d = timer_q + 12'd1;
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (timer_q == FULL_C) begin
               timer_d = '0;
               if (rx_s_q != ^shift_q) begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end else begin
                  state_d = STOP;
               end
            end else begin
               timer_d = timer_q + 12'd1;
            end
         end
`endif
         STOP: begin
            if (timer_q == FULL_C) begin
               timer_d = '0;
               if (rx_s_q) begin
                  strobe_d = 1'b1;
                  addr_d   = shift_q[2:0];
                  data_d   = shift_q[7:3];
                  state_d  = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end else begin
               timer_d = timer_q + 12'd1;
            end
         end
         WAIT_HIGH: begin
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign write_strobe = strobe_q;
   assign frame_error  = ferr_q;
   assign address      = addr_q;
   assign data         = data_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_reg_loader.sv
// Directed + randomized bench for uart_reg_loader; expected register writes come from a byte-level model.
module tb_uart_reg_loader;

   localparam int CPB = 16;
`ifdef UART_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       write_strobe;
   logic [2:0] address;
   logic [4:0] data;
   logic       frame_error;
   logic       busy;

   always #5 clk = ~clk;

   uart_reg_loader #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx(rx),
      .write_strobe(write_strobe),
      .address(address),
      .data(data),
      .frame_error(frame_error),
      .busy(busy)
   );

   // Monitor: record every register write and error pulse seen on the outputs.
   logic [7:0] got_q[$];
   int ws_cnt = 0;
   int fe_cnt = 0;
   bit overlap = 1'b0;
   always @(negedge clk) begin
      if (write_strobe) begin
         got_q.push_back({data, address});
         ws_cnt++;
      end
      if (frame_error) fe_cnt++;
      if (write_strobe && frame_error) overlap = 1'b1;
   end

   // Reference model: bytes expected to be accepted, expected error pulses, last written register.
   int   exp_q[$];
   int   exp_fe = 0;
   int   exp_addr = 0;
   int   exp_data = 0;
   int   rd_idx = 0;
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic hold_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_bad);
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(b[i]);
      if (PAR_EN) hold_bit((^b) ^ par_bad);
      hold_bit(stop_ok);
      if (stop_ok && !(PAR_EN && par_bad)) begin
         exp_q.push_back(int'(b));
         exp_addr = int'(b) % 8;
         exp_data = int'(b) / 8;
      end else begin
         exp_fe++;
      end
   endtask

   task automatic verify(input string tag);
      chk({tag, "_strobes"}, ws_cnt, exp_q.size());
      chk({tag, "_ferrs"}, fe_cnt, exp_fe);
      while (rd_idx < exp_q.size() && rd_idx < got_q.size()) begin
         chk({tag, "_addr"}, int'(got_q[rd_idx][2:0]), exp_q[rd_idx] % 8);
         chk({tag, "_data"}, int'(got_q[rd_idx][7:3]), exp_q[rd_idx] / 8);
         rd_idx++;
      end
      chk({tag, "_addr_hold"}, int'(address), exp_addr);
      chk({tag, "_data_hold"}, int'(data), exp_data);
   endtask

   initial begin
      int n;
      logic [7:0] rb;

      // Reset with idle line
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_strobe", int'(write_strobe), 0);
      chk("rst_ferr", int'(frame_error), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_addr", int'(address), 0);
      chk("rst_data", int'(data), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      // Single byte 0x2B
      send_frame(8'h2B, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      verify("byte2b");
      chk("byte2b_addr3", int'(address), 3);
      chk("byte2b_data5", int'(data), 5);

      // Back-to-back 0xFF then 0x00
      send_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      verify("b2b");

      // Four-cycle low glitch
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      n = 0;
      while (busy && n < 9) begin
         @(negedge clk);
         n++;
      end
      chk("glitch_busy", int'(busy), 0);
      repeat (CPB) @(negedge clk);
      verify("glitch");

      // Bad stop bit followed by a long break
      send_frame(8'h2B, 1'b0, 1'b0);
      repeat (40 * CPB) @(negedge clk);
      chk("break_busy_high", int'(busy), 1);
      rx = 1'b1;
      n = 0;
      while (busy && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("break_busy_low", int'(busy), 0);
      verify("break");

      // Randomized bytes, random idle gaps
      for (int k = 0; k < 6; k++) begin
         rb = 8'($urandom_range(0, 255));
         send_frame(rb, 1'b1, 1'b0);
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      verify("rand");

      // Reset in the middle of data bit 4 of 0x55
      rb = 8'h55;
      hold_bit(1'b0);
      for (int i = 0; i < 4; i++) hold_bit(rb[i]);
      rx = rb[4];
      repeat (CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      exp_addr = 0;
      exp_data = 0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_strobe", int'(write_strobe), 0);
      rst_n = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      verify("midrst");
      send_frame(8'h81, 1'b1, PAR_EN);
      repeat (4) @(negedge clk);
      verify("after_rst");
      chk("after_rst_addr", int'(address), PAR_EN ? 0 : 1);
      chk("after_rst_data", int'(data), PAR_EN ? 0 : 16);

      chk("no_overlap", int'(overlap), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
